// File: rtl/seq_normalizer_if.sv
// ---------------------------------------------------------------------------
// seq_normalizer_if
//   Request/result bundle for seq_normalizer.
//
//   master : requester side. It drives start/data_in/dir and reads the results.
//   slave  : normalizer side. It reads the request and drives the results.
//
//   Signals:
//     start     request pulse, sampled only while the normalizer is idle
//     data_in   word to normalize, captured together with start
//     dir       0 = normalize toward the MSB, 1 = normalize toward the LSB
//     busy      operation in progress (SHIFT or DONE)
//     done      single-cycle completion pulse
//     data_out  normalized word
//     shift_cnt number of positions shifted
//     zero      the captured word was all zeros
// ---------------------------------------------------------------------------
interface seq_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] shift_cnt;
  logic             zero;

  modport master (
    output start, data_in, dir,
    input  busy, done, data_out, shift_cnt, zero
  );

  modport slave (
    input  start, data_in, dir,
    output busy, done, data_out, shift_cnt, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// ---------------------------------------------------------------------------
// seq_normalizer
//   Multi-cycle normalizer, the inverse of the barrel shifter. It shifts the
//   captured word one position per cycle toward the selected end until the
//   end bit is 1. It then reports the normalized word and the distance it
//   shifted, which is the leading- or trailing-zero count of the word.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  seq_normalizer_if.slave: start/data_in/dir in,
//          busy/done/data_out/shift_cnt/zero out
//
//   Parameters:
//     WIDTH  data width (>= 2)
//     CNT_W  shift-count width (2**CNT_W >= WIDTH)
//
//   Build option:
//     NORM_STEP2_EN  when defined, SHIFT can move 2 positions per cycle if the
//                    target bit and its neighbour are both 0. The results are
//                    the same as in the default build; only the latency drops.
// ---------------------------------------------------------------------------
module seq_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic            clk,
  input logic            rst,
  seq_normalizer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic             dir_q;
  logic [CNT_W-1:0] cnt;
  logic             zero_q;

  logic             target_bit;
  logic [WIDTH-1:0] work_next;
  logic [CNT_W-1:0] cnt_next;

  // Next shift step. The step is used only while the target bit is 0.
  always_comb begin
    // NOTE: every combinational output gets a default value first, so no path
    // through this block can infer a latch.
    target_bit = dir_q ? work[0] : work[WIDTH-1];
    work_next  = dir_q ? (work >> 1) : (work << 1);
    cnt_next   = cnt + CNT_W'(1);
`ifdef NORM_STEP2_EN
    // Two zeros at the target end: a 2-position step cannot move past the
    // first 1, so the result matches two single steps.
    if (!target_bit && !(dir_q ? work[1] : work[WIDTH-2])) begin
      work_next = dir_q ? (work >> 2) : (work << 2);
      cnt_next  = cnt + CNT_W'(2);
    end
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  // Every register then samples the values from before the edge, whatever
  // order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      work   <= '0;
      dir_q  <= 1'b0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            work   <= bus.data_in;
            dir_q  <= bus.dir;
            cnt    <= '0;
            zero_q <= (bus.data_in == '0);
            // An all-zero word never reaches a 1, so it skips SHIFT.
            state  <= (bus.data_in == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (target_bit) begin
            state <= S_DONE;
          end else begin
            work <= work_next;
            cnt  <= cnt_next;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.data_out  = work;
  assign bus.shift_cnt = cnt;
  assign bus.zero      = zero_q;

endmodule

// File: doc/seq_normalizer.md
# seq_normalizer

Multi-cycle normalizer: the inverse of the datapath barrel shifter. Given a word, it derives the shift amount instead of applying one. It shifts the word one position per cycle toward the selected end until the end bit is 1. It then reports the normalized word and the distance shifted, in the `(data, shift_amt, dir)` convention the barrel shifter consumes. It sits beside the barrel shifter in the datapath, feeding leading- and trailing-zero counts for normalization and priority logic.

## Interface
Parameters:
- `WIDTH`, 8: data width, ≥ 2.
- `CNT_W`, 3: shift-count width; 2^CNT_W ≥ WIDTH required.

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  request; sampled only in IDLE.
- `data_in`  input  WIDTH  word to normalize; captured with `start`.
- `dir`  input  1  0 = normalize toward MSB (left shift, counts leading zeros); 1 = toward LSB (right shift, counts trailing zeros); captured with `start`.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  single-cycle pulse, high in DONE.
- `data_out`  output  WIDTH  normalized word; valid from `done`, held until next accepted `start`.
- `shift_cnt`  output  CNT_W  positions shifted; same validity as `data_out`.
- `zero`  output  1  captured word was all zeros; same validity.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**, `start`=1:
  - Load the working register with `data_in` and latch `dir`.
  - Clear `shift_cnt` and `zero`.
  - Go to SHIFT if `data_in`≠0.
  - If `data_in`=0, set `zero`=1, working register=0, and go directly to DONE.
- **SHIFT**, each cycle:
  - Target bit is bit WIDTH-1 for `dir`=0, bit 0 for `dir`=1.
  - If the target bit is 1, go to DONE.
  - Otherwise shift by 1 toward the target end, fill the vacated bit with 0, and increment `shift_cnt`.
- **DONE**: `done`=1 for one cycle, then return to IDLE.
- `data_out` is the working register driven directly.
- `shift_cnt` never exceeds WIDTH-1, because a nonzero word always reaches the target bit; no wrap is possible.
- `start` in SHIFT or DONE is ignored, with no queueing.
- `start` and `rst` in the same cycle: reset wins.
- `data_in` and `dir` changes after capture have no effect on an operation in progress.

## Timing
- Let `start` be sampled at edge k, and let n = leading zeros (`dir`=0) or trailing zeros (`dir`=1) of the captured word.
- `busy` rises after edge k.
- Nonzero word: SHIFT occupies n+1 cycles; `done` is high in the cycle after edge k+1+n.
  - For WIDTH=8 this gives latency 2..9 cycles.
- Zero word: `done` is high in the cycle after edge k.
- `busy` falls after the edge that leaves DONE.
- The earliest back-to-back `start` is accepted on the edge that `busy` is first sampled low.
- Reset values: state=IDLE, `busy`=0, `done`=0, `data_out`=0, `shift_cnt`=0, `zero`=0.
- `rst` in any state, including mid-SHIFT, aborts the operation and restores all reset values on the next edge. No `done` is produced.

## Configuration
- `NORM_STEP2_EN` defined, SHIFT behaviour:
  - If the target bit and its neighbour are both 0, shift by 2 and add 2 to `shift_cnt`.
  - Otherwise use the 1-bit rule above.
  - Results (`data_out`, `shift_cnt`, `zero`) are identical to the undefined case; only latency changes. SHIFT takes ⌊n/2⌋ + (n mod 2) + 1 cycles.
- `NORM_STEP2_EN` undefined: strictly 1 bit per cycle; SHIFT takes n+1 cycles.

## Test plan
All scenarios use WIDTH=8, CNT_W=3, macro undefined unless noted.
- `data_in`=0x13, `dir`=0, start at edge k → `done` after edge k+4; `data_out`=0x98, `shift_cnt`=3, `zero`=0.
- `data_in`=0xB0, `dir`=1 → `data_out`=0x0B, `shift_cnt`=4, `zero`=0; `done` after edge k+5.
- Boundaries:
  - 0x80 with `dir`=0 → `shift_cnt`=0, `data_out`=0x80, `done` after k+1.
  - 0x01 with `dir`=0 → `shift_cnt`=7, `data_out`=0x80, `done` after k+8.
- `data_in`=0x00 → `zero`=1, `data_out`=0x00, `shift_cnt`=0, `done` after edge k; `busy` high exactly 1 cycle.
- Start 0x01 with `dir`=0; pulse `start` with 0xFF mid-SHIFT → ignored, result still `shift_cnt`=7. Repeat and assert `rst` mid-SHIFT → all outputs 0 next cycle, no `done`.
- `NORM_STEP2_EN` defined, 0x13, `dir`=0 → `data_out`=0x98, `shift_cnt`=3, `done` after edge k+3.
